// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : exc_pkg
// Purpose  : Shared types and constants for the exception-handling stage.
// Revision : 1.0 - initial release
// ============================================================================
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } exc_state_t;

  localparam logic [3:0]  ESR_EXTIRQ         = 4'b0001;
  localparam logic [3:0]  ESR_BADOP          = 4'b0010;
  localparam logic [63:0] EXC_VECTOR_DEFAULT = 64'hD8;

endpackage
`default_nettype wire

// File: rtl/exception_unit.sv
`default_nettype none
// ============================================================================
// Module   : exception_unit
// Purpose  : Latches ELR/ESR, redirects fetch to/from the exception vector,
//            flushes the pipeline and acknowledges accepted exceptions.
// Revision : 1.0 - initial release
// ============================================================================
module exception_unit
  import exc_pkg::*;
#(
  parameter int unsigned      N          = 64,
  parameter logic [N-1:0]     EXC_VECTOR = N'(EXC_VECTOR_DEFAULT)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Exc,
  input  logic         ERet,
  input  logic [3:0]   EStatus,
  input  logic [N-1:0] pc_exc,
  input  logic [N-1:0] pc_next,
  input  logic         sys_sel,
  output logic         ExcAck,
  output logic         pc_redirect,
  output logic [N-1:0] pc_target,
  output logic         flush,
  output logic         in_handler,
  output logic [N-1:0] elr,
  output logic [3:0]   esr,
  output logic [N-1:0] sys_rdata,
  output logic         exc_dropped
);

  exc_state_t   r_state;
  exc_state_t   w_next_state;
  logic         w_accept;
  logic         w_drop;
  logic [N-1:0] r_elr;
  logic [3:0]   r_esr;
  logic         r_exc_dropped;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_elr         <= '0;
      r_esr         <= '0;
      r_exc_dropped <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_esr <= EStatus;
        // An IRQ interrupts between instructions, so resume after the current one.
        r_elr <= (EStatus == ESR_EXTIRQ) ? pc_next : pc_exc;
      end
      if (w_drop) begin
        r_exc_dropped <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    ExcAck       = 1'b0;
    pc_redirect  = 1'b0;
    pc_target    = '0;
    flush        = 1'b0;
    in_handler   = 1'b0;
    case (r_state)
      IDLE: begin
        if (Exc) begin
          w_accept     = 1'b1;
          w_next_state = TAKE;
        end
      end
      TAKE: begin
        ExcAck       = 1'b1;
        pc_redirect  = 1'b1;
        pc_target    = EXC_VECTOR;
        flush        = 1'b1;
        w_drop       = Exc;
        w_next_state = HANDLER;
      end
      HANDLER: begin
        in_handler = 1'b1;
        w_drop     = Exc;
        if (ERet) begin
          w_next_state = RETURN;
        end
      end
      RETURN: begin
        pc_redirect  = 1'b1;
        pc_target    = r_elr;
        flush        = 1'b1;
        in_handler   = 1'b1;
        w_drop       = Exc;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign elr         = r_elr;
  assign esr         = r_esr;
  assign exc_dropped = r_exc_dropped;
  assign sys_rdata   = sys_sel ? {{(N-4){1'b0}}, r_esr} : r_elr;

endmodule
`default_nettype wire

// File: tb/tb_exception_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_exception_unit
// Purpose  : Scoreboard bench for exception_unit: directed plan plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exception_unit;

  localparam int unsigned  N   = 64;
  localparam logic [63:0]  VEC = 64'hD8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         Exc = 1'b0, ERet = 1'b0, sys_sel = 1'b0;
  logic [3:0]   EStatus = '0;
  logic [N-1:0] pc_exc = '0, pc_next = '0;
  logic         ExcAck, pc_redirect, flush, in_handler, exc_dropped;
  logic [N-1:0] pc_target, elr, sys_rdata;
  logic [3:0]   esr;

  exception_unit #(.N(N), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .reset(reset), .Exc(Exc), .ERet(ERet), .EStatus(EStatus),
    .pc_exc(pc_exc), .pc_next(pc_next), .sys_sel(sys_sel),
    .ExcAck(ExcAck), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .flush(flush), .in_handler(in_handler), .elr(elr), .esr(esr),
    .sys_rdata(sys_rdata), .exc_dropped(exc_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ack, redir, flush, inh, dropped;
    logic [N-1:0] target, elr, rdata;
    logic [3:0]   esr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: which phase of exception service we are in, as flags.
  bit           m_taking, m_servicing, m_returning, m_dropped;
  logic [N-1:0] m_elr;
  logic [3:0]   m_esr;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, queue the expectation.
  task automatic step(input bit e, input bit r, input logic [3:0] st,
                      input logic [N-1:0] pc, input bit sel, input bit rst);
    exp_t x;
    @(negedge clk);
    reset = rst; Exc = e; ERet = r; EStatus = st; pc_exc = pc; pc_next = pc + 4; sys_sel = sel;
    if (rst) begin
      m_taking = 0; m_servicing = 0; m_returning = 0; m_dropped = 0; m_elr = '0; m_esr = '0;
    end else if (m_returning) begin
      m_returning = 0;
      if (e) m_dropped = 1;
    end else if (m_taking) begin
      m_taking = 0; m_servicing = 1;
      if (e) m_dropped = 1;
    end else if (m_servicing) begin
      if (e) m_dropped = 1;
      if (r) begin m_servicing = 0; m_returning = 1; end
    end else if (e) begin
      m_esr = st;
      m_elr = (st == 4'b0001) ? pc + 4 : pc;
      m_taking = 1;
    end
    x.ack     = m_taking;
    x.redir   = m_taking | m_returning;
    x.flush   = m_taking | m_returning;
    x.target  = m_taking ? VEC : (m_returning ? m_elr : '0);
    x.inh     = m_servicing | m_returning;
    x.dropped = m_dropped;
    x.elr     = m_elr;
    x.esr     = m_esr;
    x.rdata   = sel ? {60'd0, m_esr} : m_elr;
    exp_q.push_back(x);
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("ExcAck",      N'(ExcAck),      N'(x.ack));
        chk("pc_redirect", N'(pc_redirect), N'(x.redir));
        chk("pc_target",   pc_target,       x.target);
        chk("flush",       N'(flush),       N'(x.flush));
        chk("in_handler",  N'(in_handler),  N'(x.inh));
        chk("elr",         elr,             x.elr);
        chk("esr",         N'(esr),         N'(x.esr));
        chk("sys_rdata",   sys_rdata,       x.rdata);
        chk("exc_dropped", N'(exc_dropped), N'(x.dropped));
      end
    end
  end

  initial begin : stimulus
    logic [3:0]   st;
    logic [N-1:0] pc;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    // Invalid opcode at 0x40, then return.
    step(1, 0, 4'b0010, 64'h40, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // External IRQ at 0x80 resumes at 0x84.
    step(1, 0, 4'b0001, 64'h80, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Nested exception masked, then Exc+ERet together in the handler.
    step(1, 0, 4'b0010, 64'h200, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 4'b0001, 64'h100, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 4'b0010, 64'h300, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // ERet alone in IDLE, then Exc+ERet in IDLE, then reset during TAKE.
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 4'b0010, 64'h400, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 4'b0001, 64'h500, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0:       st = 4'b0001;
        1:       st = 4'b0010;
        default: st = 4'($urandom);
      endcase
      pc = {$urandom, $urandom};
      step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, st, pc,
           1'($urandom), $urandom_range(0, 60) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exception_unit.md
# exception_unit

Sequential exception-handling stage directly downstream of the processor controller. Consumes the controller's `Exc`, `ERet` and `EStatus` outputs. Latches the exception link and status registers, redirects fetch to the exception vector and back, flushes the pipeline, and returns the one-cycle `ExcAck` that the controller combines with `ExtIRQ` to form `ExtIAck`.

## Interface
Parameters:
- `N`, 64: datapath/PC width.
- `EXC_VECTOR`, 64'hD8: handler entry address.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `Exc` in 1: exception request from controller (external IRQ or invalid opcode).
- `ERet` in 1: exception-return instruction decoded.
- `EStatus` in 4: exception cause; 4'b0001 external IRQ, 4'b0010 invalid opcode.
- `pc_exc` in N: PC of the instruction raising/decoding the exception.
- `pc_next` in N: `pc_exc`+4.
- `sys_sel` in 1: MRS read select; 0 = ELR, 1 = ESR (zero-extended).
- `ExcAck` out 1: one-cycle acknowledge to controller.
- `pc_redirect` out 1: override fetch PC this cycle.
- `pc_target` out N: redirect address.
- `flush` out 1: squash in-flight instructions.
- `in_handler` out 1: high while servicing.
- `elr` out N: exception link register.
- `esr` out 4: exception status register.
- `sys_rdata` out N: MRS read data.
- `exc_dropped` out 1: sticky; an `Exc` was ignored.

## Operation
- States: IDLE, TAKE, HANDLER, RETURN.
- IDLE:
  - `Exc`=1 at an edge → latch `esr`<=`EStatus`.
  - `elr`<=`pc_next` if `EStatus`==4'b0001, else `pc_exc`.
  - Next state TAKE.
  - `ERet` alone in IDLE is ignored; state unchanged.
  - `Exc` and `ERet` together: `Exc` wins.
- TAKE (exactly one cycle):
  - `ExcAck`=1, `pc_redirect`=1, `pc_target`=`EXC_VECTOR`, `flush`=1.
  - Next state HANDLER.
- HANDLER:
  - `in_handler`=1.
  - `ERet`=1 → RETURN.
  - `Exc`=1 (nested) is masked: `exc_dropped`<=1, and `elr`/`esr` are unchanged.
  - `Exc` and `ERet` together: `ERet` wins and `exc_dropped` is set.
- RETURN (exactly one cycle):
  - `pc_redirect`=1, `pc_target`=`elr`, `flush`=1, `in_handler`=1.
  - Next state IDLE.
- `Exc` in TAKE or RETURN sets `exc_dropped` and is otherwise ignored.
- `exc_dropped` clears only on reset.
- `sys_rdata` is combinational from current `elr`/`esr`, valid in any state.
- Outputs not driven in a state are 0; `pc_target` is 0 when `pc_redirect`=0.
- Reset values: state IDLE, `elr`=0, `esr`=0, `exc_dropped`=0, and every output 0.
- Reset during TAKE/HANDLER/RETURN aborts to IDLE with no redirect on the following cycle.

## Timing
- `Exc` sampled at edge k → TAKE outputs (`ExcAck`, redirect, flush) during cycle k+1; handler fetch at edge k+2.
- `ERet` sampled in HANDLER at edge k → redirect to `elr` during cycle k+1.
- `ExcAck` is high for exactly one cycle per accepted exception.
- `elr`/`esr` update at the same edge as the IDLE→TAKE transition and are stable thereafter until the next accepted exception.
- `sys_rdata` follows `sys_sel` combinationally; a read during cycle k+1 returns the new `elr`/`esr`.
- Minimum spacing between two accepted exceptions: 4 cycles (TAKE, HANDLER ≥1, RETURN, IDLE).

## Structure
- Shared package `exc_pkg` holds:
  - `exc_state_t` enum {IDLE, TAKE, HANDLER, RETURN};
  - ESR cause constants `ESR_EXTIRQ`=4'b0001 and `ESR_BADOP`=4'b0010;
  - the default `EXC_VECTOR`.
- Single module. The state register, ELR/ESR registers and the output decode are all in one `always_ff` plus one `always_comb`; no sub-module is warranted.

## Test plan
- Reset held 2 cycles, then released: all outputs 0, state IDLE, `sys_rdata`=0.
- `Exc`=1, `EStatus`=4'b0010, `pc_exc`=64'h40 for 1 cycle:
  - next cycle `ExcAck`=1, `pc_redirect`=1, `pc_target`=64'hD8, `flush`=1;
  - then `elr`=64'h40, `esr`=4'b0010, `in_handler`=1.
- `Exc`=1, `EStatus`=4'b0001, `pc_exc`=64'h80, `pc_next`=64'h84: `elr`=64'h84; then `ERet`=1 in HANDLER → next cycle `pc_target`=64'h84, `flush`=1, then IDLE.
- Nested exception:
  - `Exc` pulsed with `pc_exc`=64'h100 while in HANDLER: `elr`/`esr` unchanged, `exc_dropped`=1, no `ExcAck`.
  - Same cycle `Exc` and `ERet` in HANDLER: RETURN taken.
- `ERet`=1 in IDLE: no redirect, state stays IDLE. `Exc`+`ERet` together in IDLE: TAKE entered.
- `reset` asserted during TAKE: next cycle all outputs 0, IDLE; a subsequent `Exc` is accepted normally.
